instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Sits between the program counter and instruction memory. Takes the current
//  pc and issues in-order fetch requests over a valid/ready memory port.
//  Buffers returned words with their pc and presents them to decode over a
//  valid/ready handshake.
//  Drives stall back to the program counter so pc only advances on request
//  acceptance. Discards in-flight fetches when a taken jump (flush) redirects pc.
// PARAMETERS
//  ADDR_W  32  address/pc width
//  DATA_W  32  instruction width
//  DEPTH   2   max (outstanding requests + buffered words); power of 2, >=2
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  pc             in   ADDR_W  fetch address from program counter
//  flush          in   1       redirect: pc changes next edge, kill in-flight
//  stall          out  1       1 = program counter must hold pc
//  mem_req_valid  out  1       fetch request valid
//  mem_req_addr   out  ADDR_W  fetch address (= pc, combinational)
//  mem_req_ready  in   1       memory accepts request
//  mem_rsp_valid  in   1       response word valid (in order, no backpressure)
//  mem_rsp_data   in   DATA_W  response word
//  instr_valid    out  1       instruction to decode valid
//  instr          out  DATA_W  instruction word
//  instr_pc       out  ADDR_W  pc of that instruction
//  instr_ready    in   1       decode accepts instruction
// BEHAVIOUR
//  - Reset (async, rst=1): state=FETCH, outstanding=0, fifo empty, drop_cnt=0,
//    started=0. Outputs: mem_req_valid=0, instr_valid=0, stall=1, instr=0,
//    instr_pc=0.
//  - started is set on the first clk edge after rst falls. No request is issued
//    before that edge.
//  - Credit: outstanding + fifo_count < DEPTH.
//  - mem_req_valid = started & state==FETCH & credit & !flush.
//  - stall = !(mem_req_valid & mem_req_ready); purely combinational.
//  - On accept: pc is pushed into the tag queue and outstanding increments.
//  - On mem_rsp_valid in FETCH: pop the tag and decrement outstanding.
//    Push {tag,data} into the fifo. The push cannot overflow (credit rule).
//  - Same-cycle accept and response: outstanding is unchanged; tag queue
//    push and pop are both performed.
//  - Decode side: the fifo head drives instr/instr_pc. instr_valid = fifo
//    non-empty. Pop on instr_valid & instr_ready.
//  - Default latency: mem_rsp_valid at cycle N gives instr_valid at N+1.
//  - FSM FETCH->DRAIN on flush, when outstanding after this cycle's response
//    is nonzero:
//    - drop_cnt <= that count; fifo and tag queue cleared; no request issued.
//  - FETCH->FETCH on flush when that count is zero: fifo cleared, no request
//    this cycle. Fetch resumes next cycle with the new pc.
//  - A response arriving in the same cycle as flush is discarded.
//  - DRAIN: no requests (stall=1), instr_valid=0. Each mem_rsp_valid decrements
//    drop_cnt and its data is discarded.
//  - DRAIN->FETCH on the edge where drop_cnt reaches 0. flush while in DRAIN
//    has no effect.
//  - rst mid-operation: all state cleared immediately. Late memory responses
//    to pre-reset requests are the memory's responsibility; none are expected.
//  - Counters wrap-free: outstanding, drop_cnt and fifo_count are sized
//    $clog2(DEPTH)+1 and never exceed DEPTH.
// CONFIGURATION
//  IFU_BYPASS_EN defined: when the fifo is empty and state==FETCH with no
//    flush, a response is forwarded combinationally. instr_valid=1 and
//    instr/instr_pc = mem_rsp_data/tag head in the same cycle.
//  - With bypass and instr_ready=1: the word is not written to the fifo.
//  - With bypass and instr_ready=0: the word is written to the fifo.
//  IFU_BYPASS_EN undefined: every response goes through the fifo
//    (1-cycle latency).
// TESTING
//  - Reset: rst=1 for 3 cycles -> mem_req_valid=0, stall=1, instr_valid=0.
//    First request occurs 1 cycle after rst falls, addr=pc=0.
//  - Streaming: mem_req_ready=1, memory returns 1 cycle after accept,
//    instr_ready=1 -> pc 0,4,8,... Each instr_pc matches its word. stall=0
//    in steady state.
//  - Backpressure: instr_ready=0 with DEPTH=2 -> exactly 2 requests accepted.
//    Then mem_req_valid=0 and stall=1 until decode pops.
//  - Flush with 2 outstanding: pc 0x10 redirected to 0x80 -> next 2 responses
//    dropped. First instr_pc after flush is 0x80.
//  - Flush coincident with a response -> that word is never seen on instr;
//    drop_cnt equals the remaining outstanding count.
//  - IFU_BYPASS_EN with fifo empty: mem_rsp_valid=1, data=0x00500093 ->
//    instr_valid=1 and instr=0x00500093 in the same cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order instruction fetch between the program counter and
// instruction memory. Issues credit-limited requests over a valid/ready port,
// tags each request with its pc, buffers returned words with their pc, and
// hands them to decode over valid/ready. A flush (taken jump) discards all
// buffered words and drops responses still in flight.
//
// Optional feature: define IFU_BYPASS_EN to forward a response straight to
// decode in the same cycle when the buffer is empty. Without it every word
// spends one cycle in the buffer.
module instr_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic              stall,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t state, state_nxt;
   logic   started;

   // Requests in flight, words buffered, and responses still to be discarded
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] drop_cnt;

   // Tag queue: pc of every accepted request, in issue order
   logic [ADDR_W-1:0] tagq [DEPTH];
   logic [PTR_W-1:0]  tag_wr;
   logic [PTR_W-1:0]  tag_rd;

   // Instruction buffer: returned word plus its pc
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [ADDR_W-1:0] fifo_pc   [DEPTH];
   logic [PTR_W-1:0]  fifo_wr;
   logic [PTR_W-1:0]  fifo_rd;

   logic             in_fetch;
   logic [CNT_W:0]   occupancy;
   logic             credit;
   logic             req_fire;
   logic             rsp_take;
   logic             fifo_empty;
   logic             byp;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CNT_W-1:0] rsp_left;

   // Request side: credit covers both in-flight requests and buffered words,
   // so a returning word always has a buffer slot.
   always_comb begin
      in_fetch      = (state == FETCH);
      occupancy     = {1'b0, outstanding} + {1'b0, fifo_count};
      credit        = (occupancy < (CNT_W+1)'(DEPTH));
      mem_req_valid = started & in_fetch & credit & ~flush;
      mem_req_addr  = pc;
      req_fire      = mem_req_valid & mem_req_ready;
      stall         = ~req_fire;
   end

   // Response and decode side: a response seen together with flush is dropped
   always_comb begin
      rsp_take   = mem_rsp_valid & in_fetch & ~flush;
      fifo_empty = (fifo_count == '0);
`ifdef IFU_BYPASS_EN
      byp        = rsp_take & fifo_empty;
`else
      byp        = 1'b0;
`endif
      instr_valid = ~fifo_empty | byp;
      if (byp) begin
         instr    = mem_rsp_data;
         instr_pc = tagq[tag_rd];
      end else if (!fifo_empty) begin
         instr    = fifo_data[fifo_rd];
         instr_pc = fifo_pc[fifo_rd];
      end else begin
         instr    = '0;
         instr_pc = '0;
      end
      fifo_pop  = ~fifo_empty & instr_ready;
      // A bypassed word that decode takes immediately never enters the buffer
      fifo_push = rsp_take & ~(byp & instr_ready);
      // Requests still owed by memory once this cycle's response is counted
      rsp_left  = outstanding - CNT_W'(mem_rsp_valid && (outstanding != '0));
   end

   // Next-state logic: drain in-flight responses after a redirect
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (flush && (rsp_left != '0)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (mem_rsp_valid && (drop_cnt == CNT_W'(1))) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   // Control counters and pointers; flush clears the buffer and tag queue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started     <= 1'b0;
         outstanding <= '0;
         fifo_count  <= '0;
         drop_cnt    <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
      end else begin
         started <= 1'b1;
         if (in_fetch && flush) begin
            outstanding <= '0;
            fifo_count  <= '0;
            drop_cnt    <= rsp_left;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
         end else if (in_fetch) begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            fifo_count  <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            tag_wr      <= tag_wr + PTR_W'(req_fire);
            tag_rd      <= tag_rd + PTR_W'(rsp_take);
            fifo_wr     <= fifo_wr + PTR_W'(fifo_push);
            fifo_rd     <= fifo_rd + PTR_W'(fifo_pop);
         end else if (mem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   // Data storage: tag and buffer contents are only meaningful under their counts
   always_ff @(posedge clk) begin
      if (req_fire) tagq[tag_wr] <= pc;
      if (fifo_push) begin
         fifo_data[fifo_wr] <= mem_rsp_data;
         fifo_pc[fifo_wr]   <= tagq[tag_rd];
      end
   end

   a_occupancy: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, outstanding} + {1'b0, fifo_count}) <= (CNT_W+1)'(DEPTH));

   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      mem_rsp_valid |-> ((state == FETCH) ? (outstanding != '0) : (drop_cnt != '0)));

endmodule
